// File: rtl/muldiv_iter_unit_if.sv
// Request/result bundle between the execute stage and the iterative
// multiply/divide unit. The CPU drives the request side (master); the unit
// returns busy/done and the architectural HI/LO registers (slave).
interface muldiv_iter_unit_if #(
   parameter int WIDTH = 32
);
   logic             write_en;
   logic             sin;
   logic [1:0]       op;
   logic [WIDTH-1:0] in_1;
   logic [WIDTH-1:0] in_2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output write_en, sin, op, in_1, in_2,
      input  busy, done, hi, lo
   );

   modport slave (
      input  write_en, sin, op, in_1, in_2,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative HI/LO multiply/divide unit. One bit per cycle: shift-add
// multiply and restoring divide on operand magnitudes, with the sign fixed
// up in a single closing cycle. MTHI/MTLO write HI/LO directly when idle.
module muldiv_iter_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic               clk,
   input logic               reset,
   muldiv_iter_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   // Magnitude of a possibly signed operand.
   function automatic logic [WIDTH-1:0] mag_w(input logic signed [WIDTH-1:0] v,
                                              input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   // Conditional two's-complement negate, single width.
   function automatic logic [WIDTH-1:0] neg_if_w(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      return neg ? -v : v;
   endfunction

   // Conditional two's-complement negate, double width.
   function automatic logic [2*WIDTH-1:0] neg_if_2w(input logic [2*WIDTH-1:0] v,
                                                    input logic neg);
      return neg ? -v : v;
   endfunction

   state_t             state, state_nxt;
   logic               accept, step, finish, mt_write;
   logic [CNT_W-1:0]   cnt;
   logic               busy_r, done_r;
   logic [WIDTH-1:0]   hi_r, lo_r;

   // Datapath state: for divide prod holds {remainder, dividend/quotient},
   // for multiply {partial product high, multiplier/product low}.
   logic               is_div, neg_q, neg_r;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] prod, prod_step, prod_fix;
   logic [WIDTH-1:0]   addend, div_sub, quo_fix, rem_fix;
   logic [WIDTH:0]     mul_sum, div_shift;
   logic               div_ge;

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      mt_write  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.write_en) begin
               if (bus.op[1]) begin
                  accept    = 1'b1;
                  state_nxt = RUN;
               end else begin
                  mt_write  = 1'b1;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_CNT) state_nxt = FIN;
         end
         FIN: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide.
   always_comb begin
      addend    = prod[0] ? opb : '0;
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opb};
      div_sub   = div_shift[WIDTH-1:0] - opb;
      if (is_div)
         prod_step = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};
      else
         prod_step = {mul_sum, prod[WIDTH-1:1]};
   end

   // Sign correction applied on the closing edge.
   always_comb begin
      prod_fix = neg_if_2w(prod, neg_q);
      quo_fix  = neg_if_w(prod[WIDTH-1:0], neg_q);
      rem_fix  = neg_if_w(prod[2*WIDTH-1:WIDTH], neg_r);
   end

   // Control and architectural registers: counter, busy/done, HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         done_r <= finish;
         if (accept)    cnt <= '0;
         else if (step) cnt <= cnt + CNT_W'(1);
         if (accept)      busy_r <= 1'b1;
         else if (finish) busy_r <= 1'b0;
         if (mt_write) begin
            if (bus.op[0]) lo_r <= bus.in_1;
            else           hi_r <= bus.in_1;
         end else if (finish) begin
            if (is_div) begin
               hi_r <= rem_fix;
               lo_r <= quo_fix;
            end else begin
               {hi_r, lo_r} <= prod_fix;
            end
         end
      end
   end

   // Operand capture at accept, then one iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         is_div <= bus.op[0];
         neg_q  <= bus.sin & (bus.in_1[WIDTH-1] ^ bus.in_2[WIDTH-1]);
         neg_r  <= bus.sin & bus.in_1[WIDTH-1];
         if (bus.op[0]) begin
            opb  <= mag_w(bus.in_2, bus.sin);
            prod <= {{WIDTH{1'b0}}, mag_w(bus.in_1, bus.sin)};
         end else begin
            opb  <= mag_w(bus.in_1, bus.sin);
            prod <= {{WIDTH{1'b0}}, mag_w(bus.in_2, bus.sin)};
         end
      end else if (step) begin
         prod <= prod_step;
      end
   end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Bench for muldiv_iter_unit (WIDTH=32): directed cases plus randomized
// MULT/DIV requests checked against an arithmetic reference model.
module tb_muldiv_iter_unit;
   localparam int W = 32;

   logic        clk = 1'b0;
   logic        reset;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_hi, exp_lo;

   muldiv_iter_unit_if #(.WIDTH(W)) bus();

   muldiv_iter_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic div, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = s ? longint'($signed(a)) : longint'({32'b0, a});
      sb = s ? longint'($signed(b)) : longint'({32'b0, b});
      if (!div) begin
         p = sa * sb;
         return p;
      end
      if (b == 32'h0) return {a, ((s && a[31]) ? 32'h1 : 32'hFFFF_FFFF)};
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic mt_write(input string tag, input logic is_lo, input logic [31:0] val);
      @(negedge clk);
      bus.write_en = 1'b1;
      bus.op       = {1'b0, is_lo};
      bus.in_1     = val;
      @(negedge clk);
      bus.write_en = 1'b0;
      if (is_lo) exp_lo = val;
      else       exp_hi = val;
      check({tag, "_hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
      check({tag, "_lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
      check({tag, "_busy_done"}, {62'h0, bus.busy, bus.done}, 64'h0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input bit scramble);
      logic [63:0] e;
      int n;
      e = model(op[0], s, a, b);
      @(negedge clk);
      bus.write_en = 1'b1;
      bus.op       = op;
      bus.sin      = s;
      bus.in_1     = a;
      bus.in_2     = b;
      @(negedge clk);
      if (scramble) begin
         bus.op   = 2'b01;
         bus.in_1 = 32'h1;
      end else begin
         bus.write_en = 1'b0;
      end
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         check({tag, "_hold"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
         check({tag, "_done_low"}, {63'h0, bus.done}, 64'h0);
         if (scramble) begin
            bus.in_1 = $urandom;
            bus.in_2 = $urandom;
            bus.sin  = ~bus.sin;
         end
         @(negedge clk);
      end
      bus.write_en = 1'b0;
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      check({tag, "_busy_cycles"}, 64'(n), 64'(W + 1));
      check({tag, "_done"}, {63'h0, bus.done}, 64'h1);
      check({tag, "_result"}, {bus.hi, bus.lo}, e);
      @(negedge clk);
      check({tag, "_done_pulse"}, {62'h0, bus.busy, bus.done}, 64'h0);
      check({tag, "_stable"}, {bus.hi, bus.lo}, e);
   endtask

   initial begin
      reset        = 1'b1;
      bus.write_en = 1'b0;
      bus.op       = 2'b00;
      bus.sin      = 1'b0;
      bus.in_1     = '0;
      bus.in_2     = '0;
      exp_hi       = '0;
      exp_lo       = '0;
      repeat (3) @(negedge clk);
      check("reset_hilo", {bus.hi, bus.lo}, 64'h0);
      check("reset_ctrl", {62'h0, bus.busy, bus.done}, 64'h0);
      reset = 1'b0;

      mt_write("mthi", 1'b0, 32'hDEAD_BEEF);
      mt_write("mtlo", 1'b1, 32'h0000_55AA);

      run_op("multu_max", 2'b10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max_const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_neg", 2'b10, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
      check("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("div_neg", 2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu_7_2", 2'b11, 1'b0, 32'd7, 32'd2, 1'b0);
      check("divu_7_2_const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
      run_op("div_ovf", 2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
      run_op("divu_zero", 2'b11, 1'b0, 32'h0000_1234, 32'h0, 1'b0);
      check("divu_zero_const", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
      run_op("div_zero", 2'b11, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0);
      check("div_zero_const", {bus.hi, bus.lo}, 64'hFFFF_FFF0_0000_0001);

      mt_write("mthi2", 1'b0, 32'hDEAD_BEEF);
      run_op("multu_ignore", 2'b10, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      check("multu_ignore_const", {bus.hi, bus.lo}, 64'h0B00_EA4E_242D_2080);

      // Reset in the middle of DIVU 100/7.
      @(negedge clk);
      bus.write_en = 1'b1;
      bus.op       = 2'b11;
      bus.sin      = 1'b0;
      bus.in_1     = 32'd100;
      bus.in_2     = 32'd7;
      @(negedge clk);
      bus.write_en = 1'b0;
      repeat (10) @(negedge clk);
      check("midrun_busy", {63'h0, bus.busy}, 64'h1);
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      check("midrun_reset_hilo", {bus.hi, bus.lo}, 64'h0);
      check("midrun_reset_ctrl", {62'h0, bus.busy, bus.done}, 64'h0);
      run_op("divu_100_7", 2'b11, 1'b0, 32'd100, 32'd7, 1'b0);
      check("divu_100_7_const", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  rop;
         logic        rs;
         logic [31:0] ra, rb;
         rop = {1'b1, 1'($urandom_range(0, 1))};
         rs  = 1'($urandom_range(0, 1));
         ra  = pick();
         rb  = pick();
         run_op($sformatf("rand%0d", i), rop, rs, ra, rb, 1'($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle HI/LO multiply/divide register block.
- Runs an iterative shift-add multiply and a restoring divide, one bit per cycle, over WIDTH-bit operands.
- Holds the architectural HI/LO registers.
- Sits beside the ALU in the execute stage; the CPU stalls on busy before any HI/LO read or new multiply/divide issue.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  request strobe; sampled only when busy=0.
- sin  input  1  1 = signed MULT/DIV, 0 = unsigned MULTU/DIVU; ignored for MTHI/MTLO.
- op  input  2  00 MTHI, 01 MTLO, 10 MULT(U), 11 DIV(U).
- in_1  input  WIDTH  MTHI/MTLO data, multiplicand or dividend.
- in_2  input  WIDTH  multiplier or divisor.
- busy  output  1  iterative operation in flight.
- done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, any state): hi=0, lo=0, busy=0, done=0, FSM→IDLE, counter=0.
  - Reset in mid-operation aborts the operation; no partial result is written.
- Clocking: single clock domain; all outputs registered.
- FSM states: IDLE, RUN, FIN.
- IDLE, write_en=1:
  - op=00: hi<=in_1 at the next edge; stay in IDLE; busy and done stay 0.
  - op=01: same, writing lo.
  - op=1x: latch op and sin; latch the operand magnitudes (two's-complement negate when sin=1 and the MSB is set); latch the result-sign flags; counter<=0; →RUN.
- RUN:
  - One iteration per cycle.
  - Multiply: 2·WIDTH-bit accumulator, shift-add on multiplier LSB.
  - Divide: restoring; shift the remainder left, subtract the divisor, keep the difference if it is non-negative, set the quotient bit.
  - After WIDTH iterations (counter=WIDTH-1 on the final RUN cycle) →FIN.
- FIN, one cycle; at its closing edge:
  - Apply sign correction.
  - MULT: hi:lo <= product.
  - DIV: lo <= quotient, hi <= remainder.
  - done<=1; →IDLE.
- busy=1 throughout RUN and FIN.
- Latency: accept edge E0; busy high for WIDTH+1 cycles; new hi/lo visible, with done=1 and busy=0, in the cycle after edge E(WIDTH+1). For WIDTH=32 this is 33 busy cycles.
- done stays high for exactly one cycle; it is cleared by the next edge unless reset.
- Signed multiply:
  - Product negated (2·WIDTH-bit two's complement) if the operand signs differ.
  - Full 2·WIDTH result; no overflow.
- Signed divide:
  - Quotient truncates toward zero; negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: in_1 = q·in_2 + r, with |r| < |in_2|.
- Divide by zero: runs the normal latency; no exception.
  - Unsigned: lo = all ones, hi = in_1.
  - Signed: lo = (in_1 < 0) ? 1 : all ones; hi = in_1.
- Signed overflow, most-negative / −1: lo = most-negative, hi = 0. Results wrap to WIDTH bits.
- write_en while busy=1: ignored entirely; no queuing; hi/lo and the FSM are unaffected. The CPU must hold the request until busy=0.
- Input capture:
  - in_1, in_2 and sin are captured only at the accept edge.
  - Later changes during RUN/FIN have no effect.
- hi/lo hold their previous values throughout RUN and FIN.

Test Plan:
- MULTU in_1=0xFFFFFFFF, in_2=0xFFFFFFFF (WIDTH=32) -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses for 1 cycle.
- MULT in_1=-3 (0xFFFFFFFD), in_2=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV in_1=-7, in_2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7/2 -> lo=3, hi=1; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234; DIV 0xFFFFFFF0 / 0 -> lo=0x00000001, hi=0xFFFFFFF0; both at normal latency.
- Idle behaviour and ignored requests:
  - MTHI 0xDEADBEEF in IDLE -> hi updated after 1 edge, busy and done stay 0.
  - During a subsequent MULTU, MTLO 0x1 with write_en every cycle, plus toggling in_1/in_2 -> ignored; the result matches the originally latched operands.
- Reset mid-operation:
  - Assert reset at RUN iteration 10 of DIVU 100/7 -> next cycle hi=lo=0, busy=0, done=0.
  - A fresh DIVU 100/7 afterwards -> lo=14, hi=2.
